// File: rtl/nios_cpu_oci_trace_capture.sv
// OCI debug-trace capture buffer: qualifies DCT beats into a show-ahead FIFO and
// sequences CAPTURE -> DRAIN -> ENDED. Optional build macro: OCI_TRACE_TIMESTAMP_EN.
module nios_cpu_oci_trace_capture #(
    parameter int DATA_W = 30,
    parameter int CNT_W  = 4,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] dct_buffer,
    input  logic [CNT_W-1:0]  dct_count,
    input  logic              dct_valid,
    input  logic              test_ending,
    input  logic              test_has_ended,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W:0]   fill_level,
    output logic              overflow,
    output logic [15:0]       drop_count,
    output logic              done
`ifdef OCI_TRACE_TIMESTAMP_EN
    ,
    output logic [15:0]       out_timestamp
`endif
);

    // Handshake: the head entry transfers on any rising edge where out_valid && out_ready.
    // out_valid never depends on out_ready.

    typedef enum logic [1:0] {
        ST_CAPTURE = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_ENDED   = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);

    state_t            state;
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [CNT_W-1:0]  cnt_mem  [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   fill_q;
    logic [ADDR_W:0]   fill_next;

    logic qualified;
    logic capturing;
    logic fifo_full;
    logic head_valid;
    logic pop;
    logic wr_en;
    logic drop;

    always_comb begin
        qualified  = dct_valid && (dct_count != '0);
        capturing  = (state == ST_CAPTURE);
        fifo_full  = (fill_q == FULL_LEVEL);
        head_valid = (fill_q != '0) && (state != ST_ENDED);
        pop        = head_valid && out_ready;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts the beat.
        wr_en      = capturing && qualified && (!fifo_full || pop) && !test_has_ended;
        drop       = capturing && qualified && fifo_full && !pop && !test_has_ended;
    end

    always_comb begin
        fill_next = fill_q;
        case ({wr_en, pop})
            2'b10:   fill_next = fill_q + 1'b1;
            2'b01:   fill_next = fill_q - 1'b1;
            default: fill_next = fill_q;
        endcase
    end

    // Storage has no reset; stale contents are never visible because out_* is gated by head_valid.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            data_mem[wr_ptr] <= dct_buffer;
            cnt_mem[wr_ptr]  <= dct_count;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_CAPTURE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_q     <= '0;
            overflow   <= 1'b0;
            drop_count <= 16'd0;
            done       <= 1'b0;
        end else if (test_has_ended) begin
            // Hard stop flushes the FIFO but keeps the drop statistics for post-mortem.
            state  <= ST_ENDED;
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill_q <= '0;
            done   <= 1'b1;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fill_q <= fill_next;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF) begin
                    drop_count <= drop_count + 16'd1;
                end
            end
            case (state)
                ST_CAPTURE: begin
                    if (test_ending) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (fill_next == '0) begin
                        state <= ST_ENDED;
                        done  <= 1'b1;
                    end
                end
                ST_ENDED: begin
                    state <= ST_ENDED;
                    done  <= 1'b1;
                end
                default: begin
                    state <= ST_ENDED;
                    done  <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        out_valid  = head_valid;
        out_data   = head_valid ? data_mem[rd_ptr] : '0;
        out_count  = head_valid ? cnt_mem[rd_ptr] : '0;
        fill_level = fill_q;
    end

`ifdef OCI_TRACE_TIMESTAMP_EN
    logic [15:0] ts_q;
    logic [15:0] ts_mem [DEPTH];

    // Free-running in every state, so deltas between stored beats equal cycle distance.
    always_ff @(posedge clk) begin
        if (reset) begin
            ts_q <= 16'd0;
        end else begin
            ts_q <= ts_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            ts_mem[wr_ptr] <= ts_q;
        end
    end

    always_comb begin
        out_timestamp = head_valid ? ts_mem[rd_ptr] : 16'd0;
    end
`endif

endmodule

// File: tb/tb_nios_cpu_oci_trace_capture.sv
// Bench for nios_cpu_oci_trace_capture: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_nios_cpu_oci_trace_capture;

    localparam int DATA_W = 30;
    localparam int CNT_W  = 4;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    localparam int M_CAP   = 0;
    localparam int M_DRAIN = 1;
    localparam int M_END   = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [DATA_W-1:0] dct_buffer = '0;
    logic [CNT_W-1:0]  dct_count = '0;
    logic              dct_valid = 1'b0;
    logic              test_ending = 1'b0;
    logic              test_has_ended = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  out_count;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [ADDR_W:0]   fill_level;
    logic              overflow;
    logic [15:0]       drop_count;
    logic              done;
`ifdef OCI_TRACE_TIMESTAMP_EN
    logic [15:0]       out_timestamp;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nios_cpu_oci_trace_capture #(
        .DATA_W(DATA_W), .CNT_W(CNT_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .dct_buffer(dct_buffer),
        .dct_count(dct_count),
        .dct_valid(dct_valid),
        .test_ending(test_ending),
        .test_has_ended(test_has_ended),
        .out_data(out_data),
        .out_count(out_count),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .fill_level(fill_level),
        .overflow(overflow),
        .drop_count(drop_count),
        .done(done)
`ifdef OCI_TRACE_TIMESTAMP_EN
        ,
        .out_timestamp(out_timestamp)
`endif
    );

    // Reference model: a plain queue of stored beats plus a mode number.
    typedef struct {
        logic [DATA_W-1:0] data;
        logic [CNT_W-1:0]  cnt;
        logic [15:0]       ts;
    } entry_t;

    entry_t      m_q[$];
    int          m_mode = M_CAP;
    logic        m_ovf = 1'b0;
    int          m_drops = 0;
    logic [15:0] m_ts = 16'd0;

    task automatic model_step();
        bit     popped;
        bit     qual;
        bit     can_push;
        entry_t e;
        if (reset) begin
            m_q.delete();
            m_mode  = M_CAP;
            m_ovf   = 1'b0;
            m_drops = 0;
            m_ts    = 16'd0;
        end else begin
            if (test_has_ended) begin
                m_q.delete();
                m_mode = M_END;
            end else if (m_mode != M_END) begin
                popped   = (m_q.size() > 0) && out_ready;
                qual     = dct_valid && (dct_count != 0);
                can_push = (m_q.size() < DEPTH) || popped;
                if (popped) void'(m_q.pop_front());
                if (m_mode == M_CAP && qual) begin
                    if (can_push) begin
                        e.data = dct_buffer;
                        e.cnt  = dct_count;
                        e.ts   = m_ts;
                        m_q.push_back(e);
                    end else begin
                        m_ovf = 1'b1;
                        if (m_drops < 65535) m_drops++;
                    end
                end
                if (m_mode == M_CAP && test_ending) m_mode = M_DRAIN;
                else if (m_mode == M_DRAIN && m_q.size() == 0) m_mode = M_END;
            end
            m_ts = m_ts + 16'd1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        bit m_valid;
        m_valid = (m_mode != M_END) && (m_q.size() > 0);
        check("fill_level", 32'(fill_level), 32'(m_q.size()));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_data", 32'(out_data), m_valid ? 32'(m_q[0].data) : 32'd0);
        check("out_count", 32'(out_count), m_valid ? 32'(m_q[0].cnt) : 32'd0);
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("drop_count", 32'(drop_count), 32'(m_drops));
        check("done", 32'(done), 32'(m_mode == M_END));
`ifdef OCI_TRACE_TIMESTAMP_EN
        check("out_timestamp", 32'(out_timestamp), m_valid ? 32'(m_q[0].ts) : 32'd0);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_model();
    endtask

    task automatic drive(input logic v, input logic [CNT_W-1:0] c, input logic [DATA_W-1:0] d,
                         input logic rdy, input logic te, input logic the);
        dct_valid      = v;
        dct_count      = c;
        dct_buffer     = d;
        out_ready      = rdy;
        test_ending    = te;
        test_has_ended = the;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
    endtask

    task automatic fill_beats(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, CNT_W'((i % 15) + 1), DATA_W'(base + i), 1'b0, 1'b0, 1'b0);
            tick();
        end
    endtask

    typedef struct {
        logic              v;
        logic [CNT_W-1:0]  cnt;
        logic [DATA_W-1:0] data;
        logic              rdy;
        logic [ADDR_W:0]   exp_fill;
        logic              exp_valid;
        logic [DATA_W-1:0] exp_data;
        logic [CNT_W-1:0]  exp_cnt;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int pops;
        vecs[0] = '{1'b1, 4'd1, 30'h0A1, 1'b0, 5'd1, 1'b1, 30'h0A1, 4'd1};
        vecs[1] = '{1'b1, 4'd2, 30'h0B2, 1'b0, 5'd2, 1'b1, 30'h0A1, 4'd1};
        vecs[2] = '{1'b1, 4'd3, 30'h0C3, 1'b0, 5'd3, 1'b1, 30'h0A1, 4'd1};
        vecs[3] = '{1'b1, 4'd0, 30'h0DD, 1'b0, 5'd3, 1'b1, 30'h0A1, 4'd1};
        vecs[4] = '{1'b0, 4'd5, 30'h0EE, 1'b1, 5'd2, 1'b1, 30'h0B2, 4'd2};
        vecs[5] = '{1'b0, 4'd0, 30'h000, 1'b1, 5'd1, 1'b1, 30'h0C3, 4'd3};
        vecs[6] = '{1'b1, 4'd4, 30'h044, 1'b1, 5'd1, 1'b1, 30'h044, 4'd4};
        vecs[7] = '{1'b0, 4'd0, 30'h000, 1'b1, 5'd0, 1'b0, 30'h000, 4'd0};
        vecs[8] = '{1'b0, 4'd0, 30'h000, 1'b1, 5'd0, 1'b0, 30'h000, 4'd0};

        // Reset state
        do_reset();
        check("rst_fill", 32'(fill_level), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_drops", 32'(drop_count), 32'd0);
        check("rst_done", 32'(done), 32'd0);

        // Ordered capture/readout, empty beats, pop+write, empty ready
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].v, vecs[i].cnt, vecs[i].data, vecs[i].rdy, 1'b0, 1'b0);
            tick();
            check($sformatf("vec%0d_fill", i), 32'(fill_level), 32'(vecs[i].exp_fill));
            check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_data", i), 32'(out_data), 32'(vecs[i].exp_data));
            check($sformatf("vec%0d_count", i), 32'(out_count), 32'(vecs[i].exp_cnt));
        end
        check("vec_drops", 32'(drop_count), 32'd0);

        // Overflow: 18 beats into 16 entries, then full with beat + pop
        do_reset();
        fill_beats(18, 'h200);
        check("ovf_fill", 32'(fill_level), 32'd16);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_drops", 32'(drop_count), 32'd2);
        drive(1'b1, 4'd9, 30'h100, 1'b1, 1'b0, 1'b0);
        tick();
        check("fullpop_fill", 32'(fill_level), 32'd16);
        check("fullpop_drops", 32'(drop_count), 32'd2);
        drive(1'b0, 4'd0, 30'h0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) tick();
        check("fullpop_last_fill", 32'(fill_level), 32'd1);
        check("fullpop_last_data", 32'(out_data), 32'h100);
        tick();
        check("fullpop_empty", 32'(out_valid), 32'd0);

        // Orderly stop: 5 beats, test_ending with a beat, drain with ignored beats
        do_reset();
        fill_beats(5, 'h300);
        drive(1'b1, 4'd7, 30'h3FF, 1'b0, 1'b1, 1'b0);
        tick();
        check("te_fill", 32'(fill_level), 32'd6);
        check("te_done", 32'(done), 32'd0);
        pops = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            drive(1'b1, 4'd5, DATA_W'(32'h3A0 + i), 1'b1, 1'b0, 1'b0);
            tick();
            pops++;
            if (fill_level == 1) check("drain_not_done", 32'(done), 32'd0);
        end
        check("drain_pops", 32'(pops), 32'd6);
        check("drain_done", 32'(done), 32'd1);
        check("drain_drops", 32'(drop_count), 32'd0);

        // Hard stop with 7 entries after overflow
        do_reset();
        fill_beats(18, 'h400);
        drive(1'b0, 4'd0, 30'h0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) tick();
        check("he_pre_fill", 32'(fill_level), 32'd7);
        drive(1'b1, 4'd3, 30'h4FF, 1'b0, 1'b1, 1'b1);
        tick();
        check("he_fill", 32'(fill_level), 32'd0);
        check("he_valid", 32'(out_valid), 32'd0);
        check("he_done", 32'(done), 32'd1);
        check("he_drops", 32'(drop_count), 32'd2);
        check("he_overflow", 32'(overflow), 32'd1);
        drive(1'b1, 4'd3, 30'h4FE, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        check("ended_absorb", 32'(done), 32'd1);

        // Reset mid-capture dominates a simultaneous beat
        do_reset();
        fill_beats(4, 'h500);
        reset = 1'b1;
        drive(1'b1, 4'd2, 30'h5AA, 1'b1, 1'b1, 1'b1);
        tick();
        reset = 1'b0;
        check("midrst_fill", 32'(fill_level), 32'd0);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_overflow", 32'(overflow), 32'd0);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            reset = (done && $urandom_range(0, 7) == 0) || ($urandom_range(0, 299) == 0);
            drive($urandom_range(0, 2) != 0,
                  ($urandom_range(0, 3) == 0) ? CNT_W'(0) : CNT_W'($urandom),
                  DATA_W'($urandom),
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 119) == 0,
                  $urandom_range(0, 499) == 0);
            tick();
        end
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
